// File: rtl/key_poll_pkg.sv
// Shared types and width helpers for the key_poll_master Avalon-MM key poller.
package key_poll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    CAP  = 2'd3
  } kp_state_t;

  localparam int KP_ADDR_W = 2;
  localparam int KP_DATA_W = 32;

  // Poll timer holds 0 .. poll_div-1.
  function automatic int KP_TIMER_W(input int poll_div);
    return (poll_div > 2) ? $clog2(poll_div) : 1;
  endfunction

  // Latency counter holds 0 .. read_latency-1.
  function automatic int KP_LAT_W(input int read_latency);
    return (read_latency > 2) ? $clog2(read_latency) : 1;
  endfunction

  // Debounce counter saturates at debounce_cnt.
  function automatic int KP_CNT_W(input int debounce_cnt);
    return $clog2(debounce_cnt + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-vector key debouncer with press/release pulse generation.
// With KEY_POLL_DEBOUNCE_EN undefined every strobed sample is accepted directly.
module key_debounce
  import key_poll_pkg::*;
#(
  parameter int KEY_W        = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] sample,
  input  logic             strobe,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  logic [KEY_W-1:0] state_r;
  logic [KEY_W-1:0] press_r;
  logic [KEY_W-1:0] release_r;
  logic [KEY_W-1:0] next_state_s;

`ifdef KEY_POLL_DEBOUNCE_EN
  localparam int               CNT_W   = KP_CNT_W(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [KEY_W-1:0] cand_r;
  logic [KEY_W-1:0] cand_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Candidate tracking and acceptance decision for the current strobe.
  always_comb begin
    cand_s       = cand_r;
    cnt_s        = cnt_r;
    next_state_s = state_r;
    if (strobe) begin
      if (sample == cand_r) begin
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end else begin
        cand_s = sample;
        cnt_s  = CNT_ONE;
      end
      // Acceptance uses the updated count so the Nth stable sample takes effect at once.
      if ((cnt_s == CNT_MAX) && (cand_s != state_r)) begin
        next_state_s = cand_s;
      end else begin
        next_state_s = state_r;
      end
    end else begin
      next_state_s = state_r;
    end
  end

  // Candidate and stability counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_r <= {KEY_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      cand_r <= cand_s;
      cnt_r  <= cnt_s;
    end
  end
`else
  localparam int unused_debounce_cnt = DEBOUNCE_CNT;

  // Undebounced path: each strobed sample is the new state.
  always_comb begin
    if (strobe) begin
      next_state_s = sample;
    end else begin
      next_state_s = state_r;
    end
  end
`endif

  // Debounced state and edge pulses, all registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= {KEY_W{1'b0}};
      press_r   <= {KEY_W{1'b0}};
      release_r <= {KEY_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      press_r   <= next_state_s & ~state_r;
      release_r <= ~next_state_s & state_r;
    end
  end

  assign key_state   = state_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM read initiator polling a key PIO, with debounce and press/release pulses.
// Optional debounce stage is built when KEY_POLL_DEBOUNCE_EN is defined.
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int KEY_W          = 2,
  parameter int POLL_DIV       = 50000,
  parameter int READ_LATENCY   = 1,
  parameter int KEY_ADDR       = 0,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CNT   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [KP_ADDR_W-1:0] avm_address,
  output logic                 avm_read,
  input  logic [KP_DATA_W-1:0] avm_readdata,
  input  logic                 avm_waitrequest,
  output logic [KEY_W-1:0]     key_state,
  output logic [KEY_W-1:0]     key_press,
  output logic [KEY_W-1:0]     key_release,
  output logic                 sample_valid
);

  localparam int                   TIMER_W      = KP_TIMER_W(POLL_DIV);
  localparam int                   LAT_W        = KP_LAT_W(READ_LATENCY);
  localparam logic [TIMER_W-1:0]   TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);
  localparam logic [TIMER_W-1:0]   TIMER_ZERO   = TIMER_W'(0);
  localparam logic [TIMER_W-1:0]   TIMER_ONE    = TIMER_W'(1);
  localparam logic [LAT_W-1:0]     LAT_ZERO     = LAT_W'(0);
  localparam logic [LAT_W-1:0]     LAT_ONE      = LAT_W'(1);
  localparam logic [LAT_W-1:0]     LAT_LAST     = LAT_W'(READ_LATENCY - 1);
  localparam logic [KP_ADDR_W-1:0] ADDR         = KP_ADDR_W'(KEY_ADDR);
  localparam logic [KEY_W-1:0]     POL_MASK     = (KEY_ACTIVE_LOW != 0) ? {KEY_W{1'b1}} : {KEY_W{1'b0}};

  kp_state_t          state_r;
  kp_state_t          state_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_s;
  logic [LAT_W-1:0]   lat_r;
  logic [LAT_W-1:0]   lat_s;
  logic               capture_s;
  logic [KEY_W-1:0]   sample_r;
  logic               avm_read_r;
  logic               sample_valid_r;
  logic               unused_readdata_s;

  // Only the low KEY_W bits of readdata carry key information.
  assign unused_readdata_s = ^avm_readdata;

  // Free-running poll timer, parked at reload while disabled in IDLE.
  always_comb begin
    if (!enable && (state_r == IDLE)) begin
      timer_s = TIMER_RELOAD;
    end else if (timer_r == TIMER_ZERO) begin
      timer_s = TIMER_RELOAD;
    end else begin
      timer_s = timer_r - TIMER_ONE;
    end
  end

  // Read sequencing; expiries seen outside IDLE are dropped, not queued.
  always_comb begin
    state_s   = state_r;
    lat_s     = lat_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (timer_r == TIMER_ZERO)) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_s = WAIT;
          lat_s   = LAT_ZERO;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (lat_r == LAT_LAST) begin
          state_s   = CAP;
          capture_s = 1'b1;
        end else begin
          lat_s = lat_r + LAT_ONE;
        end
      end
      CAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, timer and latency counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      timer_r <= TIMER_RELOAD;
      lat_r   <= LAT_ZERO;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      lat_r   <= lat_s;
    end
  end

  // Bus request, polarity-normalised capture and sample strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read_r     <= 1'b0;
      sample_r       <= {KEY_W{1'b0}};
      sample_valid_r <= 1'b0;
    end else begin
      avm_read_r     <= (state_s == REQ);
      sample_valid_r <= (state_r == CAP);
      if (capture_s) begin
        sample_r <= avm_readdata[KEY_W-1:0] ^ POL_MASK;
      end else begin
        sample_r <= sample_r;
      end
    end
  end

  key_debounce #(
    .KEY_W        (KEY_W),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample_r),
    .strobe      (state_r == CAP),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release)
  );

  assign avm_address  = ADDR;
  assign avm_read     = avm_read_r;
  assign sample_valid = sample_valid_r;

endmodule
